// File: rtl/lsu_initiator.sv
// Load/store initiator for the MEM stage: one word-aligned req/ack access per
// pipeline request, with lane steering, load extension and fault/timeout detection.
module lsu_initiator #(
  parameter int DM_BYTES = 4096,
  parameter int TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ls_valid,
  input  logic        ls_write,
  input  logic [1:0]  ls_size,
  input  logic        ls_signed,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [31:0] ls_pc,
  output logic        ls_busy,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        ls_exc,
  output logic [1:0]  ls_exc_code,
  output logic [31:0] ls_bad_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam int            CW         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);
  localparam logic [31:0]   ADDR_LIMIT = 32'(DM_BYTES);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    size_r;
  logic [1:0]    off_r;
  logic          sgn_r;

  logic          misaligned;
  logic          out_of_range;
  logic [3:0]    be_in;
  logic [31:0]   wdata_in;
  logic [31:0]   lane;
  logic [31:0]   load_val;

  assign ls_busy = (state != IDLE);

  assign misaligned   = (ls_size == 2'b11) ||
                        (ls_size == 2'b01 && ls_addr[0]) ||
                        (ls_size == 2'b10 && ls_addr[1:0] != 2'b00);
  assign out_of_range = (ls_addr >= ADDR_LIMIT);

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = ls_wdata;
    case (ls_size)
      2'b00: begin
        be_in    = 4'b0001 << ls_addr[1:0];
        wdata_in = {4{ls_wdata[7:0]}};
      end
      2'b01: begin
        be_in    = ls_addr[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{ls_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend from its top bit.
  assign lane = mem_rdata >> {off_r, 3'b000};

  always_comb begin
    load_val = lane;
    case (size_r)
      2'b00:   load_val = {{24{sgn_r & lane[7]}}, lane[7:0]};
      2'b01:   load_val = {{16{sgn_r & lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      size_r      <= '0;
      off_r       <= '0;
      sgn_r       <= 1'b0;
      ls_done     <= 1'b0;
      ls_rdata    <= '0;
      ls_exc      <= 1'b0;
      ls_exc_code <= '0;
      ls_bad_addr <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
      mem_pc      <= '0;
    end else begin
      ls_done     <= 1'b0;
      ls_exc      <= 1'b0;
      ls_exc_code <= 2'b00;
      case (state)
        IDLE: begin
          if (ls_valid) begin
            size_r <= ls_size;
            off_r  <= ls_addr[1:0];
            sgn_r  <= ls_signed;
            if (misaligned || out_of_range) begin
              state       <= RESP;
              ls_done     <= 1'b1;
              ls_exc      <= 1'b1;
              ls_exc_code <= misaligned ? 2'b01 : 2'b10;
              ls_bad_addr <= ls_addr;
              ls_rdata    <= '0;
            end else begin
              state     <= REQ;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= ls_write;
              mem_addr  <= {ls_addr[31:2], 2'b00};
              mem_be    <= be_in;
              mem_wdata <= wdata_in;
              mem_pc    <= ls_pc;
            end
          end
        end
        REQ: begin
          // An ack on the last permitted cycle takes precedence over the timeout.
          if (mem_ack) begin
            state    <= RESP;
            mem_req  <= 1'b0;
            ls_done  <= 1'b1;
            ls_rdata <= mem_we ? 32'd0 : load_val;
          end else if (cnt == CNT_LAST) begin
            state       <= RESP;
            mem_req     <= 1'b0;
            ls_done     <= 1'b1;
            ls_exc      <= 1'b1;
            ls_exc_code <= 2'b11;
            ls_bad_addr <= {mem_addr[31:2], off_r};
            ls_rdata    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_initiator.sv
// Bench for lsu_initiator: directed vector table, reset corner sequence and
// randomized accesses checked against an arithmetic reference model.
module tb_lsu_initiator;

  localparam int DM_BYTES = 4096;
  localparam int TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        ls_valid, ls_write, ls_signed;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_pc;
  logic        ls_busy, ls_done, ls_exc;
  logic [31:0] ls_rdata, ls_bad_addr;
  logic [1:0]  ls_exc_code;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_pc, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_initiator #(.DM_BYTES(DM_BYTES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .ls_valid(ls_valid), .ls_write(ls_write), .ls_size(ls_size),
    .ls_signed(ls_signed), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_pc(ls_pc),
    .ls_busy(ls_busy), .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_exc(ls_exc),
    .ls_exc_code(ls_exc_code), .ls_bad_addr(ls_bad_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_pc(mem_pc), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] memWord;
    int          ackAt;
    int          expReq;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    int          expDone;
    logic        expExc;
    logic [1:0]  expCode;
    logic [31:0] expRdata;
  } vec_t;

  typedef struct {
    int          req;
    logic [3:0]  be;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    int          unstable;
    int          done;
    logic        exc;
    logic [1:0]  code;
    logic [31:0] rdata;
    logic [31:0] bad;
    int          after;
  } obs_t;

  function automatic vec_t mkVec(logic w, logic [1:0] sz, logic sg, logic [31:0] a,
                                 logic [31:0] wd, logic [31:0] mw, int ack,
                                 int eReq, logic [3:0] eBe, logic [31:0] eWd,
                                 int eDone, logic eExc, logic [1:0] eCode,
                                 logic [31:0] eRd);
    vec_t v;
    v.write = w;  v.size = sz;  v.sgn = sg;  v.addr = a;  v.wdata = wd;
    v.pc = a ^ 32'h8000_1234;  v.memWord = mw;  v.ackAt = ack;
    v.expReq = eReq;  v.expBe = eBe;  v.expWdata = eWd;  v.expDone = eDone;
    v.expExc = eExc;  v.expCode = eCode;  v.expRdata = eRd;
    return v;
  endfunction

  // Reference: derive expectations from access size in bytes and byte offset.
  function automatic vec_t refModel(vec_t v);
    vec_t        e = v;
    int          nb = 1 << v.size;
    int          off = int'(v.addr % 4);
    logic [31:0] mask, lane, full;
    e.expBe = 4'b0000;  e.expWdata = 32'd0;  e.expRdata = 32'd0;
    if (v.size == 2'd3 || (v.addr % nb) != 0) begin
      e.expReq = 0;  e.expDone = 1;  e.expExc = 1'b1;  e.expCode = 2'd1;
    end else if (v.addr >= DM_BYTES) begin
      e.expReq = 0;  e.expDone = 1;  e.expExc = 1'b1;  e.expCode = 2'd2;
    end else begin
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      full = (32'd1 << nb) - 32'd1;
      e.expBe = 4'(full << off);
      e.expWdata = (v.wdata & mask) *
                   ((nb == 1) ? 32'h0101_0101 : (nb == 2) ? 32'h0001_0001 : 32'd1);
      if (v.ackAt < 1 || v.ackAt > TIMEOUT) begin
        e.expReq = TIMEOUT;  e.expDone = TIMEOUT + 1;  e.expExc = 1'b1;  e.expCode = 2'd3;
      end else begin
        e.expReq = v.ackAt;  e.expDone = v.ackAt + 1;  e.expExc = 1'b0;  e.expCode = 2'd0;
        lane = (v.memWord >> (8 * off)) & mask;
        if (v.sgn && nb < 4 && lane[8 * nb - 1]) lane = lane | ~mask;
        e.expRdata = v.write ? 32'd0 : lane;
      end
    end
    return e;
  endfunction

  task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic scramble();
    ls_write  = 1'($urandom);
    ls_size   = 2'($urandom);
    ls_signed = 1'($urandom);
    ls_addr   = $urandom;
    ls_wdata  = $urandom;
    ls_pc     = $urandom;
  endtask

  // Present one access, play memory with the requested ack cycle, record what happened.
  task automatic applyStimulus(input vec_t v, output obs_t o);
    o = '{default: 0};
    @(negedge clk);
    ls_valid = 1'b1;  ls_write = v.write;  ls_size = v.size;  ls_signed = v.sgn;
    ls_addr = v.addr;  ls_wdata = v.wdata;  ls_pc = v.pc;  mem_ack = 1'b0;
    @(negedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      scramble();
      ls_valid = 1'($urandom);
      if (mem_req) begin
        o.req++;
        if (o.req == 1) begin
          o.be = mem_be;  o.we = mem_we;  o.addr = mem_addr;
          o.wdata = mem_wdata;  o.pc = mem_pc;
        end else if (mem_be !== o.be || mem_we !== o.we || mem_addr !== o.addr ||
                     mem_wdata !== o.wdata || mem_pc !== o.pc) begin
          o.unstable++;
        end
        mem_ack   = (o.req == v.ackAt);
        mem_rdata = mem_ack ? v.memWord : $urandom;
      end else begin
        mem_ack = 1'b0;
      end
      if (ls_done) begin
        o.done = cyc;  o.exc = ls_exc;  o.code = ls_exc_code;
        o.rdata = ls_rdata;  o.bad = ls_bad_addr;
        ls_valid = 1'b0;  mem_ack = 1'b0;
        @(negedge clk);
        o.after = int'(ls_done) + int'(ls_busy) + int'(ls_exc) + int'(mem_req) +
                  ((ls_rdata !== o.rdata) ? 1 : 0);
        break;
      end
      if (!ls_busy || ls_exc) o.unstable++;
      @(negedge clk);
    end
    ls_valid = 1'b0;
    mem_ack  = 1'b0;
  endtask

  task automatic checkOutput(input vec_t e, input obs_t o, input string tag);
    checkVal({tag, ".reqCycles"}, o.req, e.expReq);
    if (e.expReq > 0) begin
      checkVal({tag, ".be"}, {28'd0, o.be}, {28'd0, e.expBe});
      checkVal({tag, ".we"}, {31'd0, o.we}, {31'd0, e.write});
      checkVal({tag, ".addr"}, o.addr, e.addr & 32'hFFFF_FFFC);
      checkVal({tag, ".pc"}, o.pc, e.pc);
      checkVal({tag, ".unstable"}, o.unstable, 0);
      if (e.write) checkVal({tag, ".wdata"}, o.wdata, e.expWdata);
    end
    checkVal({tag, ".doneCycle"}, o.done, e.expDone);
    checkVal({tag, ".exc"}, {31'd0, o.exc}, {31'd0, e.expExc});
    checkVal({tag, ".code"}, {30'd0, o.code}, {30'd0, e.expCode});
    checkVal({tag, ".rdata"}, o.rdata, e.expRdata);
    if (e.expExc) checkVal({tag, ".badAddr"}, o.bad, e.addr);
    checkVal({tag, ".afterDone"}, o.after, 0);
  endtask

  vec_t table_v[$];
  vec_t v, e;
  obs_t o;

  initial begin
    reset = 1'b1;  ls_valid = 1'b1;  ls_write = 1'b1;  ls_size = 2'b10;  ls_signed = 1'b0;
    ls_addr = 32'h10;  ls_wdata = 32'h1234_5678;  ls_pc = 32'h40;
    mem_rdata = 32'd0;  mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    checkVal("rst.busy", {31'd0, ls_busy}, 32'd0);
    checkVal("rst.done", {31'd0, ls_done}, 32'd0);
    checkVal("rst.exc", {29'd0, ls_exc, ls_exc_code}, 32'd0);
    checkVal("rst.rdata", ls_rdata, 32'd0);
    checkVal("rst.bad", ls_bad_addr, 32'd0);
    checkVal("rst.req", {30'd0, mem_req, mem_we}, 32'd0);
    checkVal("rst.maddr", mem_addr, 32'd0);
    checkVal("rst.be", {28'd0, mem_be}, 32'd0);
    checkVal("rst.mwdata", mem_wdata, 32'd0);
    checkVal("rst.mpc", mem_pc, 32'd0);
    ls_valid = 1'b0;
    reset    = 1'b0;

    //                  w  sz    sg  addr          wdata          memWord        ack req be       wdata        done exc code rdata
    table_v.push_back(mkVec(1, 2'd2, 0, 32'h10,   32'hDEADBEEF, 32'h0,         1,  1, 4'b1111, 32'hDEADBEEF, 2, 0, 2'd0, 32'h0));
    table_v.push_back(mkVec(1, 2'd0, 0, 32'h7,    32'h85,       32'h0,         1,  1, 4'b1000, 32'h85858585, 2, 0, 2'd0, 32'h0));
    table_v.push_back(mkVec(0, 2'd0, 1, 32'h7,    32'h0,        32'h85000000,  2,  2, 4'b1000, 32'h0,        3, 0, 2'd0, 32'hFFFFFF85));
    table_v.push_back(mkVec(0, 2'd0, 0, 32'h7,    32'h0,        32'h85000000,  1,  1, 4'b1000, 32'h0,        2, 0, 2'd0, 32'h00000085));
    table_v.push_back(mkVec(0, 2'd1, 1, 32'h2,    32'h0,        32'h80011234,  1,  1, 4'b1100, 32'h0,        2, 0, 2'd0, 32'hFFFF8001));
    table_v.push_back(mkVec(0, 2'd1, 1, 32'h3,    32'h0,        32'h0,         1,  0, 4'b0000, 32'h0,        1, 1, 2'd1, 32'h0));
    table_v.push_back(mkVec(0, 2'd2, 0, 32'h1000, 32'h0,        32'h0,         1,  0, 4'b0000, 32'h0,        1, 1, 2'd2, 32'h0));
    table_v.push_back(mkVec(0, 2'd2, 0, 32'h1001, 32'h0,        32'h0,         1,  0, 4'b0000, 32'h0,        1, 1, 2'd1, 32'h0));
    table_v.push_back(mkVec(0, 2'd2, 0, 32'h20,   32'h0,        32'h11111111,  0, 16, 4'b1111, 32'h0,       17, 1, 2'd3, 32'h0));
    table_v.push_back(mkVec(0, 2'd2, 0, 32'h24,   32'h0,        32'h12345678, 16, 16, 4'b1111, 32'h0,       17, 0, 2'd0, 32'h12345678));
    table_v.push_back(mkVec(0, 2'd3, 0, 32'h40,   32'h0,        32'h0,         1,  0, 4'b0000, 32'h0,        1, 1, 2'd1, 32'h0));
    table_v.push_back(mkVec(0, 2'd1, 0, 32'h2,    32'h0,        32'h80011234,  1,  1, 4'b1100, 32'h0,        2, 0, 2'd0, 32'h00008001));
    table_v.push_back(mkVec(1, 2'd1, 0, 32'h6,    32'h1234ABCD, 32'h0,         3,  3, 4'b1100, 32'hABCDABCD, 4, 0, 2'd0, 32'h0));
    table_v.push_back(mkVec(1, 2'd0, 0, 32'hFFF,  32'h7F,       32'h0,         1,  1, 4'b1000, 32'h7F7F7F7F, 2, 0, 2'd0, 32'h0));
    table_v.push_back(mkVec(0, 2'd2, 1, 32'hFFC,  32'h0,        32'hCAFEF00D,  5,  5, 4'b1111, 32'h0,        6, 0, 2'd0, 32'hCAFEF00D));
    table_v.push_back(mkVec(1, 2'd2, 0, 32'h1004, 32'h55,       32'h0,         1,  0, 4'b0000, 32'h0,        1, 1, 2'd2, 32'h0));
    table_v.push_back(mkVec(0, 2'd0, 1, 32'h4,    32'h0,        32'h0000007F,  1,  1, 4'b0001, 32'h0,        2, 0, 2'd0, 32'h0000007F));

    foreach (table_v[i]) begin
      applyStimulus(table_v[i], o);
      checkOutput(table_v[i], o, $sformatf("vec%0d", i));
    end

    // Reset during the third REQ cycle aborts silently; a stray ack in IDLE is ignored.
    @(negedge clk);
    ls_valid = 1'b1;  ls_write = 1'b0;  ls_size = 2'b10;  ls_addr = 32'h30;  mem_ack = 1'b0;
    @(negedge clk);
    ls_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("rstReq.reqBefore", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkVal("rstReq.req", {31'd0, mem_req}, 32'd0);
    checkVal("rstReq.busy", {31'd0, ls_busy}, 32'd0);
    checkVal("rstReq.done", {31'd0, ls_done}, 32'd0);
    mem_ack = 1'b1;  mem_rdata = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge clk);
      checkVal("stray.state", {29'd0, ls_busy, ls_done, mem_req}, 32'd0);
    end
    mem_ack = 1'b0;
    v = mkVec(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 1, 1, 4'b1111, 32'hDEADBEEF, 2, 0, 2'd0, 32'h0);
    applyStimulus(v, o);
    checkOutput(v, o, "postRst");

    for (int n = 0; n < 40; n++) begin
      int r;
      v.write   = 1'($urandom);
      v.size    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      v.sgn     = 1'($urandom);
      v.wdata   = $urandom;
      v.pc      = $urandom;
      v.memWord = $urandom;
      r = $urandom_range(0, 9);
      if (r < 6)       v.addr = 32'($urandom_range(0, DM_BYTES - 1)) & ~((32'd1 << v.size) - 32'd1);
      else if (r < 8)  v.addr = 32'($urandom_range(0, DM_BYTES - 1));
      else if (r == 8) v.addr = 32'(DM_BYTES + $urandom_range(0, 64));
      else             v.addr = $urandom;
      v.ackAt = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, TIMEOUT);
      e = refModel(v);
      applyStimulus(v, o);
      checkOutput(e, o, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_initiator.md
Name: lsu_initiator

Overview:
- Load/store initiator in the MEM stage. Accepts one load or store from the pipeline and issues a single word-aligned request to data memory using a req/ack handshake.
- Builds byte enables and lane-replicated write data. Extracts and sign- or zero-extends load data from the returned word.
- Detects misaligned, out-of-range and timed-out accesses, and stalls the pipeline via ls_busy while an access is outstanding.

Parameters:
DM_BYTES, 4096, size of data memory in bytes; valid addresses are 0 to DM_BYTES-1.
TIMEOUT, 16, maximum cycles mem_req is held without mem_ack before the access is aborted (minimum 2).

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
ls_valid  input  1  pipeline presents an access; sampled only in IDLE
ls_write  input  1  1 = store, 0 = load
ls_size  input  2  00 byte, 01 half, 10 word, 11 illegal
ls_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
ls_addr  input  32  byte address
ls_wdata  input  32  store data, right-justified
ls_pc  input  32  PC of the access instruction
ls_busy  output  1  stall request to the pipeline
ls_done  output  1  one-cycle completion pulse
ls_rdata  output  32  extended load result
ls_exc  output  1  exception flag, valid with ls_done
ls_exc_code  output  2  01 misaligned/illegal size, 10 out of range, 11 timeout
ls_bad_addr  output  32  faulting address, valid with ls_exc
mem_req  output  1  request to memory
mem_we  output  1  write enable
mem_addr  output  32  word address, {addr[31:2],2'b00}
mem_be  output  4  byte enables
mem_wdata  output  32  lane-replicated write data
mem_pc  output  32  latched ls_pc, for memory write logging
mem_rdata  input  32  read word
mem_ack  input  1  memory completion; meaningful only while mem_req=1

Behaviour:
- States: IDLE, REQ, RESP. ls_busy = (state != IDLE), combinational.
- Acceptance:
  - IDLE with ls_valid=1 latches all ls_* inputs at the clock edge; the pipeline need not hold them afterwards.
  - ls_valid is ignored in REQ and RESP.
- Checks, evaluated on the inputs at acceptance, in priority order:
  - size 11, half with addr[0]=1, or word with addr[1:0]!=0 gives code 01.
  - Otherwise, addr >= DM_BYTES gives code 10.
  - On any check failure: go straight to RESP, no mem_req is issued, ls_bad_addr = ls_addr.
- Lanes:
  - byte: be = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - word: be = 1111.
  - Loads drive be the same way with mem_we=0.
- REQ:
  - mem_req=1; mem_addr, mem_be, mem_wdata, mem_we and mem_pc are held stable from the latched values.
  - On an edge with mem_ack=1: capture mem_rdata and go to RESP; mem_req drops at that edge.
- Timeout:
  - Counter cleared on entry to REQ and incremented on each REQ edge without ack.
  - If the count equals TIMEOUT-1 and mem_ack=0 at that edge, go to RESP with code 11. mem_req is therefore high for at most TIMEOUT cycles.
  - Ack on the final cycle wins over timeout.
- RESP:
  - ls_done=1 for exactly one cycle, then IDLE. ls_exc and ls_exc_code are valid only when ls_done=1 and read 0 otherwise.
  - Loads: ls_rdata = the selected lane, extended per ls_signed.
  - Stores and exceptions: ls_rdata = 0.
  - ls_rdata and ls_bad_addr hold their values until the next ls_done.
- Latency, from the acceptance edge:
  - ack in the first REQ cycle puts ls_done in the 2nd cycle after acceptance;
  - ack after k REQ cycles puts ls_done in cycle k+1;
  - exceptions put ls_done in the 1st cycle.
- Reset:
  - All outputs 0, state IDLE, counter 0.
  - Reset mid-REQ drops mem_req at that edge with no ls_done.
  - mem_ack arriving in IDLE is ignored.
- A new access can be accepted in the cycle after RESP, giving back-to-back accesses every 3 cycles minimum.

Test Plan:
- sw: addr 0x10, wdata 0xDEADBEEF, ack on first REQ cycle -> mem_addr 0x10, be 1111, we 1, mem_wdata 0xDEADBEEF; ls_done 2 cycles after acceptance; ls_exc 0.
- sb then lb/lbu: sb addr 0x7 data 0x85 gives be 1000 and wdata 0x85858585. lb addr 0x7 with mem_rdata 0x85000000 returns 0xFFFFFF85; lbu returns 0x00000085.
- lh addr 0x2 with mem_rdata 0x8001_1234 and ls_signed=1 -> ls_rdata 0xFFFF8001, be 1100. Misaligned lh addr 0x3 -> no mem_req, ls_done next cycle, exc code 01, bad_addr 0x3.
- lw addr 0x1000 (DM_BYTES=4096) -> code 10, no mem_req. lw addr 0x1001 -> code 01 (misalignment has priority).
- mem_ack held low -> mem_req high exactly 16 cycles, then ls_done with code 11. Repeat with ack on the 16th cycle -> normal completion, no exception.
- Assert reset during REQ cycle 3 -> next cycle mem_req=0, ls_busy=0, no ls_done. A stray mem_ack afterwards has no effect. A new sw completes normally.
